fft_bitrev_pingpong: RTL and testbench

- Parametrised input stage for the streaming FFT path. Replaces the fixed 8-point, 50-bit frame capture.
- Collects N-point frames from an AXI-Stream-style source into one of two ping-pong banks.
- Writes each sample at its bit-reversed address, so frames are read out in the order the butterfly stages need.
- Streams each completed frame out with a sample index and tlast. Detects tlast framing errors.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_frame_bank.sv | 27 ++
 rtl/fft_bitrev_pingpong.sv | 141 ++++++++++++++
 tb/tb_fft_bitrev_pingpong.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, sample type and bit-reversal helper for the FFT input path.
package fft_pkg;

   localparam int unsigned FFT_N_POINTS = 8;
   localparam int unsigned FFT_DATA_W   = 50;

   typedef logic [FFT_DATA_W-1:0] sample_t;

   // Shifts the low log2n bits of idx out LSB-first into the result, reversing their order.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int unsigned log2n);
      logic [31:0] src;
      logic [31:0] r;
      src = idx;
      r   = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < log2n) begin
            r   = {r[30:0], src[0]};
            src = src >> 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of sample storage: synchronous write port, combinational read mux.
module fft_frame_bank
   import fft_pkg::*;
#(
   parameter int unsigned N_POINTS = FFT_N_POINTS,
   parameter int unsigned DATA_W   = FFT_DATA_W,
   parameter int unsigned LOG2N    = $clog2(N_POINTS)
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [LOG2N-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [LOG2N-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [N_POINTS];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fft_bitrev_pingpong.sv
// Ping-pong frame capture for the streaming FFT: bit-reversed write, natural-order
// read-out with index/tlast, and tlast framing-error detection.
module fft_bitrev_pingpong
   import fft_pkg::*;
#(
   parameter int unsigned N_POINTS  = FFT_N_POINTS,
   parameter int unsigned DATA_W    = FFT_DATA_W,
   parameter int unsigned BITREV_EN = 1,
   parameter int unsigned LOG2N     = $clog2(N_POINTS)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tlast,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tlast,
   output logic [LOG2N-1:0]  m_idx,
   output logic              err_early_o,
   output logic              err_late_o,
   output logic [1:0]        frames_pending_o
);

   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N_POINTS - 1);

   logic              ready_en;
   logic [LOG2N-1:0]  wr_cnt;
   logic [LOG2N-1:0]  rd_cnt;
   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic [LOG2N-1:0]  wr_addr;
   logic [DATA_W-1:0] bank_rdata [2];

   logic in_fire;
   logic out_fire;
   logic wr_last;
   logic rd_last;
   logic commit;
   logic release_bank;

   assign s_tready     = ready_en & ~full[wr_bank];
   assign in_fire      = s_tvalid & s_tready;
   assign wr_last      = (wr_cnt == CNT_LAST);
   assign commit       = in_fire & wr_last;

   assign m_tvalid     = full[rd_bank];
   assign out_fire     = m_tvalid & m_tready;
   assign rd_last      = (rd_cnt == CNT_LAST);
   assign release_bank = out_fire & rd_last;

   assign wr_addr = (BITREV_EN != 0) ? LOG2N'(bitrev(32'(wr_cnt), LOG2N)) : wr_cnt;

   // Commit and release always target different banks, so both updates can apply together.
   always_comb begin
      full_nxt = full;
      if (commit) begin
         full_nxt[wr_bank] = 1'b1;
      end
      if (release_bank) begin
         full_nxt[rd_bank] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_en    <= 1'b0;
         full        <= '0;
         wr_cnt      <= '0;
         wr_bank     <= 1'b0;
         err_early_o <= 1'b0;
         err_late_o  <= 1'b0;
      end else begin
         ready_en    <= 1'b1;
         full        <= full_nxt;
         err_early_o <= in_fire & s_tlast & ~wr_last;
         err_late_o  <= commit & ~s_tlast;
         if (in_fire) begin
            if (wr_last || s_tlast) begin
               wr_cnt <= '0;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
            if (wr_last) begin
               wr_bank <= ~wr_bank;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_cnt  <= '0;
         rd_bank <= 1'b0;
      end else if (out_fire) begin
         if (rd_last) begin
            rd_cnt  <= '0;
            rd_bank <= ~rd_bank;
         end else begin
            rd_cnt <= rd_cnt + 1'b1;
         end
      end
   end

   fft_frame_bank #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W),
      .LOG2N    (LOG2N)
   ) u_bank0 (
      .clk_i (clk_i),
      .we    (in_fire & ~wr_bank),
      .waddr (wr_addr),
      .wdata (s_tdata),
      .raddr (rd_cnt),
      .rdata (bank_rdata[0])
   );

   fft_frame_bank #(
      .N_POINTS (N_POINTS),
      .DATA_W   (DATA_W),
      .LOG2N    (LOG2N)
   ) u_bank1 (
      .clk_i (clk_i),
      .we    (in_fire & wr_bank),
      .waddr (wr_addr),
      .wdata (s_tdata),
      .raddr (rd_cnt),
      .rdata (bank_rdata[1])
   );

   // Bank storage is never reset, so data is gated to zero whenever nothing is valid.
   assign m_tdata          = m_tvalid ? bank_rdata[rd_bank] : '0;
   assign m_idx            = rd_cnt;
   assign m_tlast          = rd_last;
   assign frames_pending_o = {1'b0, full[0]} + {1'b0, full[1]};

endmodule

// File: tb/tb_fft_bitrev_pingpong.sv
// Directed bench for fft_bitrev_pingpong: a bit-reversing and a natural-order
// instance share one stimulus stream and are checked against hand-derived orders.
module tb_fft_bitrev_pingpong;

   localparam int unsigned N = 8;
   localparam int unsigned W = 50;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         s_tvalid = 1'b0;
   logic [W-1:0] s_tdata  = '0;
   logic         s_tlast  = 1'b0;
   logic         m_tready = 1'b0;

   logic         s_tready, m_tvalid, m_tlast, err_early, err_late;
   logic [W-1:0] m_tdata;
   logic [2:0]   m_idx;
   logic [1:0]   pend;

   logic         n_s_tready, n_m_tvalid, n_m_tlast, n_err_early, n_err_late;
   logic [W-1:0] n_m_tdata;
   logic [2:0]   n_m_idx;
   logic [1:0]   n_pend;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned rd_pos      = 0;
   int unsigned br [8]      = '{0, 4, 2, 6, 1, 5, 3, 7};

   always #5 clk = ~clk;

   fft_bitrev_pingpong #(
      .N_POINTS  (N),
      .DATA_W    (W),
      .BITREV_EN (1)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .s_tvalid         (s_tvalid),
      .s_tready         (s_tready),
      .s_tdata          (s_tdata),
      .s_tlast          (s_tlast),
      .m_tvalid         (m_tvalid),
      .m_tready         (m_tready),
      .m_tdata          (m_tdata),
      .m_tlast          (m_tlast),
      .m_idx            (m_idx),
      .err_early_o      (err_early),
      .err_late_o       (err_late),
      .frames_pending_o (pend)
   );

   fft_bitrev_pingpong #(
      .N_POINTS  (N),
      .DATA_W    (W),
      .BITREV_EN (0)
   ) dut_nat (
      .clk_i            (clk),
      .rst_i            (rst),
      .s_tvalid         (s_tvalid),
      .s_tready         (n_s_tready),
      .s_tdata          (s_tdata),
      .s_tlast          (s_tlast),
      .m_tvalid         (n_m_tvalid),
      .m_tready         (m_tready),
      .m_tdata          (n_m_tdata),
      .m_tlast          (n_m_tlast),
      .m_idx            (n_m_idx),
      .err_early_o      (n_err_early),
      .err_late_o       (n_err_late),
      .frames_pending_o (n_pend)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int unsigned k;
      k = 0;
      @(negedge clk);
      while (!s_tready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!s_tready) chk("s_tready_timeout", 64'(s_tready), 64'd1);
   endtask

   // last_at beyond N-1 means the frame carries no tlast at all.
   task automatic feed(input int unsigned base, input int unsigned n, input int unsigned last_at);
      for (int unsigned i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = W'(base + i);
         s_tlast  = (i == last_at);
         wait_ready();
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain(input int unsigned base, input bit nogap);
      int unsigned k;
      m_tready = 1'b1;
      for (int unsigned j = 0; j < N; j++) begin
         @(negedge clk);
         if (!nogap) begin
            k = 0;
            while (!m_tvalid && k < 300) begin
               @(negedge clk);
               k++;
            end
         end
         chk("m_tvalid", 64'(m_tvalid), 64'd1);
         chk("m_tdata", 64'(m_tdata), 64'(base + br[j]));
         chk("m_idx", 64'(m_idx), 64'(j));
         chk("m_tlast", 64'(m_tlast), 64'(j == N - 1));
         chk("nat_m_tvalid", 64'(n_m_tvalid), 64'd1);
         chk("nat_m_tdata", 64'(n_m_tdata), 64'(base + j));
         tick();
      end
   endtask

   initial begin
      // reset values while rst is held
      @(negedge clk);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_m_tdata", 64'(m_tdata), 64'd0);
      chk("rst_m_idx", 64'(m_idx), 64'd0);
      chk("rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("rst_errs", 64'({err_early, err_late}), 64'd0);
      chk("rst_pend", 64'(pend), 64'd0);
      chk("rst_nat", 64'({n_s_tready, n_m_tvalid, n_m_tlast, n_m_idx, n_err_early, n_err_late, n_pend}), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("post_rst_s_tready", 64'(s_tready), 64'd1);
      chk("post_rst_nat_s_tready", 64'(n_s_tready), 64'd1);
      tick();

      // single frame, output 0,4,2,6,1,5,3,7 one cycle after the committing beat
      m_tready = 1'b1;
      feed(0, 7, 99);
      @(negedge clk);
      chk("pre_commit_m_tvalid", 64'(m_tvalid), 64'd0);
      tick();
      feed(7, 1, 0);
      drain(0, 1'b1);

      // two frames fill both banks, third waits for a release
      m_tready = 1'b0;
      feed(0, 8, 7);
      feed(8, 8, 7);
      @(negedge clk);
      chk("full_s_tready", 64'(s_tready), 64'd0);
      chk("full_pend", 64'(pend), 64'd2);
      chk("stall_m_tdata", 64'(m_tdata), 64'd0);
      tick();
      @(negedge clk);
      chk("stall_m_tdata_hold", 64'(m_tdata), 64'd0);
      chk("stall_m_idx_hold", 64'(m_idx), 64'd0);
      tick();
      fork
         feed(16, 8, 7);
         begin
            drain(0, 1'b0);
            drain(8, 1'b1);
            drain(16, 1'b1);
         end
      join
      @(negedge clk);
      chk("drained_pend", 64'(pend), 64'd0);
      tick();

      // early tlast discards the partial frame
      m_tready = 1'b0;
      feed(20, 4, 3);
      @(negedge clk);
      chk("early_pulse", 64'(err_early), 64'd1);
      chk("early_no_late", 64'(err_late), 64'd0);
      chk("early_pend", 64'(pend), 64'd0);
      tick();
      @(negedge clk);
      chk("early_pulse_end", 64'(err_early), 64'd0);
      tick();
      feed(10, 8, 7);
      @(negedge clk);
      chk("early_next_pend", 64'(pend), 64'd1);
      chk("early_next_no_err", 64'({err_early, err_late}), 64'd0);
      tick();
      drain(10, 1'b1);

      // missing tlast still commits the frame
      m_tready = 1'b0;
      feed(30, 8, 99);
      @(negedge clk);
      chk("late_pulse", 64'(err_late), 64'd1);
      chk("late_no_early", 64'(err_early), 64'd0);
      chk("late_pend", 64'(pend), 64'd1);
      tick();
      @(negedge clk);
      chk("late_pulse_end", 64'(err_late), 64'd0);
      tick();
      drain(30, 1'b1);

      // random backpressure: every cycle the presented sample must be the expected one
      m_tready = 1'b0;
      feed(40, 8, 7);
      rd_pos = 0;
      for (int unsigned c = 0; c < 200 && rd_pos < N; c++) begin
         m_tready = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (m_tvalid) begin
            chk("rand_m_tdata", 64'(m_tdata), 64'(40 + br[rd_pos]));
            chk("rand_m_idx", 64'(m_idx), 64'(rd_pos));
            if (m_tready) rd_pos++;
         end
         tick();
      end
      chk("rand_done", 64'(rd_pos), 64'(N));

      // reset with a pending frame and a partial input frame
      m_tready = 1'b0;
      feed(50, 8, 7);
      feed(60, 4, 99);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_s_tready", 64'(s_tready), 64'd0);
      chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("midrst_m_tdata", 64'(m_tdata), 64'd0);
      chk("midrst_pend", 64'(pend), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("after_rst_s_tready", 64'(s_tready), 64'd1);
      chk("after_rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("after_rst_m_tdata", 64'(m_tdata), 64'd0);
      chk("after_rst_m_idx", 64'(m_idx), 64'd0);
      chk("after_rst_m_tlast", 64'(m_tlast), 64'd0);
      chk("after_rst_pend", 64'(pend), 64'd0);
      chk("after_rst_errs", 64'({err_early, err_late}), 64'd0);
      tick();
      feed(70, 8, 7);
      drain(70, 1'b1);
      @(negedge clk);
      chk("final_errs", 64'({err_early, err_late}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
